// File: rtl/clk_div_cfg_ctrl.sv
// clk_div_cfg_ctrl: arbitrates two ratio-change requesters and sequences
// each change into the clock divider as gate -> load -> settle -> done,
// so the divider ratio only ever moves while its enable is held low.
//
// Handshake: a requester raises valid with a stable ratio and holds both
// until it sees ready; a transfer happens on the rising edge where
// valid && ready. Ready is combinational, offered only in IDLE and only to
// one requester at a time. Dropping valid before ready withdraws the request.
module clk_div_cfg_ctrl #(
  parameter logic [7:0] RESET_RATIO   = 8'd1,
  parameter int         GATE_CYCLES   = 2,
  parameter int         SETTLE_CYCLES = 4
) (
  input  logic       i_ref_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_ratio,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_ratio,
  output logic       o_req1_ready,
  output logic [7:0] o_div_ratio,
  output logic       o_clk_en,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_done_id,
  output logic       o_done_rej,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GATE   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] GATE_INIT   = 8'(GATE_CYCLES);
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ratio_q, ratio_d;
  logic [7:0] cap_ratio_q, cap_ratio_d;
  logic       cap_id_q, cap_id_d;
  logic       last_q, last_d;
  logic       clk_en_q, clk_en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       done_id_q, done_id_d;
  logic       done_rej_q, done_rej_d;

  logic       grant0, grant1;
  logic       xfer;
  logic       xfer_id;
  logic [7:0] xfer_ratio;

  // Round-robin grant: a lone valid wins, a tie goes to the one not served last.
  always_comb begin
    grant0       = i_req0_valid && (!i_req1_valid || last_q);
    grant1       = i_req1_valid && (!i_req0_valid || !last_q);
    o_req0_ready = (state_q == S_IDLE) && !i_rst && grant0;
    o_req1_ready = (state_q == S_IDLE) && !i_rst && grant1;
    xfer         = o_req0_ready || o_req1_ready;
    xfer_id      = o_req1_ready;
    xfer_ratio   = o_req1_ready ? i_req1_ratio : i_req0_ratio;
  end

  // Sequencer next-state; every output is computed here and registered below.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    cap_ratio_d = cap_ratio_q;
    cap_id_d    = cap_id_q;
    last_d      = last_q;
    clk_en_d    = clk_en_q;
    done_d      = 1'b0;
    done_id_d   = 1'b0;
    done_rej_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_en_d = 1'b1;
        if (xfer) begin
          last_d      = xfer_id;
          cap_ratio_d = xfer_ratio;
          cap_id_d    = xfer_id;
          if (xfer_ratio == 8'd0) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            done_id_d  = xfer_id;
            done_rej_d = 1'b1;
          end else if (xfer_ratio == ratio_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            done_id_d = xfer_id;
          end else begin
            state_d  = S_GATE;
            cnt_d    = GATE_INIT;
            clk_en_d = 1'b0;
          end
        end
      end
      S_GATE: begin
        clk_en_d = 1'b0;
        cnt_d    = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Enable is still low in this cycle; it rises on the same edge the
        // new ratio lands, so the divider never sees a ratio move while enabled.
        ratio_d  = cap_ratio_q;
        state_d  = S_SETTLE;
        cnt_d    = SETTLE_INIT;
        clk_en_d = 1'b1;
      end
      S_SETTLE: begin
        clk_en_d = 1'b1;
        cnt_d    = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = cap_id_q;
        end
      end
      S_DONE: begin
        clk_en_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        clk_en_d = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      ratio_q     <= RESET_RATIO;
      cap_ratio_q <= 8'd0;
      cap_id_q    <= 1'b0;
      last_q      <= 1'b1;
      clk_en_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      done_rej_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      cap_ratio_q <= cap_ratio_d;
      cap_id_q    <= cap_id_d;
      last_q      <= last_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      done_rej_q  <= done_rej_d;
    end
  end

  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_done_id   = done_id_q;
  assign o_done_rej  = done_rej_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: default-parameter instance plus a fast
// (gate 1 / settle 1) instance. Done events are scored against a queue
// filled when a handshake is seen.
module tb_clk_div_cfg_ctrl;

  localparam int G = 2;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (defaults) ----------------
  logic       i_req0_valid = 1'b0;
  logic [7:0] i_req0_ratio = 8'd0;
  logic       i_req1_valid = 1'b0;
  logic [7:0] i_req1_ratio = 8'd0;
  logic       o_req0_ready, o_req1_ready;
  logic [7:0] o_div_ratio;
  logic       o_clk_en, o_busy, o_done, o_done_id, o_done_rej;
  logic [2:0] o_dbg_state;

  clk_div_cfg_ctrl dut (
    .i_ref_clk    (clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_ratio (i_req0_ratio),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_ratio (i_req1_ratio),
    .o_req1_ready (o_req1_ready),
    .o_div_ratio  (o_div_ratio),
    .o_clk_en     (o_clk_en),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_done_id    (o_done_id),
    .o_done_rej   (o_done_rej),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- DUT (gate 1, settle 1) ----------------
  logic       f_v0 = 1'b0;
  logic [7:0] f_r0 = 8'd0;
  logic       f_v1 = 1'b0;
  logic [7:0] f_r1 = 8'd0;
  logic       f_rdy0, f_rdy1;
  logic [7:0] f_div;
  logic       f_en, f_busy, f_done, f_done_id, f_done_rej;
  logic [2:0] f_dbg;

  clk_div_cfg_ctrl #(
    .RESET_RATIO   (8'd1),
    .GATE_CYCLES   (1),
    .SETTLE_CYCLES (1)
  ) dut_fast (
    .i_ref_clk    (clk),
    .i_rst        (i_rst),
    .i_req0_valid (f_v0),
    .i_req0_ratio (f_r0),
    .o_req0_ready (f_rdy0),
    .i_req1_valid (f_v1),
    .i_req1_ratio (f_r1),
    .o_req1_ready (f_rdy1),
    .o_div_ratio  (f_div),
    .o_clk_en     (f_en),
    .o_busy       (f_busy),
    .o_done       (f_done),
    .o_done_id    (f_done_id),
    .o_done_rej   (f_done_rej),
    .o_dbg_state  (f_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];     // {id, rej, ratio after completion}
  int         grant_id_q[$];
  int         grant_cyc_q[$];
  logic [7:0] m_ratio = 8'd1;

  logic       prev_en    = 1'b0;
  logic [7:0] prev_ratio = 8'd0;
  logic       rst_seen   = 1'b1;

  // Record handshakes, score done pulses, and watch the ratio/enable rule.
  always @(negedge clk) begin
    logic [9:0] e;
    if (i_req0_valid && o_req0_ready) begin
      if (i_req0_ratio == 8'd0) e = {1'b0, 1'b1, m_ratio};
      else begin m_ratio = i_req0_ratio; e = {1'b0, 1'b0, i_req0_ratio}; end
      exp_q.push_back(e);
      grant_id_q.push_back(0);
      grant_cyc_q.push_back(cyc);
    end
    if (i_req1_valid && o_req1_ready) begin
      if (i_req1_ratio == 8'd0) e = {1'b1, 1'b1, m_ratio};
      else begin m_ratio = i_req1_ratio; e = {1'b1, 1'b0, i_req1_ratio}; end
      exp_q.push_back(e);
      grant_id_q.push_back(1);
      grant_cyc_q.push_back(cyc);
    end
    if (o_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got id=%0d rej=%0d ratio=%0d exp no done", o_done_id, o_done_rej, o_div_ratio);
      end else begin
        e = exp_q.pop_front();
        if ({o_done_id, o_done_rej, o_div_ratio} !== e) begin
          errors++;
          $display("FAIL sb_done got %h exp %h", {o_done_id, o_done_rej, o_div_ratio}, e);
        end
      end
    end
    if (!rst_seen && o_clk_en === 1'b1 && prev_en === 1'b1) begin
      checks++;
      if (o_div_ratio !== prev_ratio) begin
        errors++;
        $display("FAIL ratio_while_enabled got %0d exp %0d", o_div_ratio, prev_ratio);
      end
    end
    prev_en    = o_clk_en;
    prev_ratio = o_div_ratio;
    rst_seen   = i_rst;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset;
    i_rst = 1'b1;
    step(2);
    i_rst = 1'b0;
    exp_q.delete();
    grant_id_q.delete();
    grant_cyc_q.delete();
    m_ratio = 8'd1;
  endtask

  // Hold a request until ready, then release right after the transfer edge.
  task automatic req(input bit id, input logic [7:0] r, output int waits);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    if (id) begin i_req1_valid = 1'b1; i_req1_ratio = r; end
    else    begin i_req0_valid = 1'b1; i_req0_ratio = r; end
    while (!got && n < 100) begin
      @(negedge clk);
      if (id ? o_req1_ready : o_req0_ready) got = 1'b1;
      else n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout id=%0d got no ready exp ready within 100 cycles", id);
    end else begin
      @(posedge clk);
    end
    #1;
    if (id) i_req1_valid = 1'b0;
    else    i_req0_valid = 1'b0;
    waits = n;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((o_busy !== 1'b0 || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout got busy=%0d pending=%0d exp 0/0", o_busy, exp_q.size());
    end
    step(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    i_rst = 1'b1;
    i_req0_valid = 1'b1;
    i_req0_ratio = 8'd9;
    step(3);
    @(negedge clk);
    checks++;
    if ({o_div_ratio, o_clk_en, o_busy, o_done, o_done_id, o_done_rej, o_req0_ready, o_req1_ready, o_dbg_state}
        !== {8'd1, 1'b1, 6'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_values got ratio=%0d en=%0d busy=%0d done=%0d id=%0d rej=%0d rdy=%0d%0d st=%0d",
               o_div_ratio, o_clk_en, o_busy, o_done, o_done_id, o_done_rej, o_req0_ready, o_req1_ready, o_dbg_state);
    end
    checks++;
    if ({f_div, f_en, f_busy, f_done, f_rdy0, f_rdy1} !== {8'd1, 1'b1, 4'b0}) begin
      errors++;
      $display("FAIL reset_fast got ratio=%0d en=%0d busy=%0d done=%0d exp 1/1/0/0", f_div, f_en, f_busy, f_done);
    end
    @(posedge clk); #1;
    i_req0_valid = 1'b0;
    i_rst = 1'b0;
    m_ratio = 8'd1;
  endtask

  task automatic test_basic;
    int w;
    logic [7:0] er;
    logic       een, ebusy, edone;
    logic [2:0] est;
    req(1'b0, 8'd4, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL basic_ready got wait=%0d exp 0", w); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      een   = !(k >= 1 && k <= G + 1);
      er    = (k >= G + 2) ? 8'd4 : 8'd1;
      edone = (k == G + S + 2);
      ebusy = (k >= 1 && k <= G + S + 2);
      if (k <= G)              est = 3'd1;
      else if (k == G + 1)     est = 3'd2;
      else if (k <= G + S + 1) est = 3'd3;
      else if (k == G + S + 2) est = 3'd4;
      else                     est = 3'd0;
      checks++;
      if ({o_clk_en, o_busy, o_done, o_done_id, o_done_rej, o_div_ratio, o_dbg_state}
          !== {een, ebusy, edone, 1'b0, 1'b0, er, est}) begin
        errors++;
        $display("FAIL basic_T+%0d got en=%0d busy=%0d done=%0d id=%0d ratio=%0d st=%0d exp en=%0d busy=%0d done=%0d id=0 ratio=%0d st=%0d",
                 k, o_clk_en, o_busy, o_done, o_done_id, o_div_ratio, o_dbg_state, een, ebusy, edone, er, est);
      end
    end
    step(1);
    wait_idle();
  endtask

  task automatic tie_pair(input logic [7:0] r0, input logic [7:0] r1, input string nm);
    int w0, w1;
    grant_id_q.delete();
    grant_cyc_q.delete();
    fork
      req(1'b0, r0, w0);
      req(1'b1, r1, w1);
    join
    wait_idle();
    checks++;
    if (grant_id_q.size() != 2) begin
      errors++;
      $display("FAIL %s_grants got %0d grants exp 2", nm, grant_id_q.size());
    end else begin
      if (grant_id_q[0] != 0 || grant_id_q[1] != 1) begin
        errors++;
        $display("FAIL %s_order got %0d,%0d exp 0,1", nm, grant_id_q[0], grant_id_q[1]);
      end
      checks++;
      if (grant_cyc_q[1] - grant_cyc_q[0] != G + S + 3) begin
        errors++;
        $display("FAIL %s_spacing got %0d exp %0d", nm, grant_cyc_q[1] - grant_cyc_q[0], G + S + 3);
      end
    end
    checks++;
    if (o_div_ratio !== r1) begin
      errors++;
      $display("FAIL %s_final_ratio got %0d exp %0d", nm, o_div_ratio, r1);
    end
  endtask

  task automatic test_tie;
    apply_reset();
    tie_pair(8'd6, 8'd9, "tie1");
    tie_pair(8'd3, 8'd7, "tie2");
  endtask

  task automatic test_reject;
    int w;
    req(1'b1, 8'd0, w);
    @(negedge clk);
    checks++;
    if ({o_done, o_done_rej, o_done_id, o_clk_en, o_div_ratio} !== {4'b1111, 8'd7}) begin
      errors++;
      $display("FAIL reject_T+1 got done=%0d rej=%0d id=%0d en=%0d ratio=%0d exp 1/1/1/1/7",
               o_done, o_done_rej, o_done_id, o_clk_en, o_div_ratio);
    end
    @(negedge clk);
    checks++;
    if ({o_done, o_busy, o_clk_en, o_div_ratio} !== {3'b001, 8'd7}) begin
      errors++;
      $display("FAIL reject_T+2 got done=%0d busy=%0d en=%0d ratio=%0d exp 0/0/1/7", o_done, o_busy, o_clk_en, o_div_ratio);
    end
    step(1);
  endtask

  task automatic test_same_ratio;
    int w;
    apply_reset();
    req(1'b0, 8'd1, w);
    @(negedge clk);
    checks++;
    if ({o_done, o_done_rej, o_done_id, o_clk_en, o_busy, o_div_ratio} !== {5'b10011, 8'd1}) begin
      errors++;
      $display("FAIL same_T+1 got done=%0d rej=%0d id=%0d en=%0d busy=%0d ratio=%0d exp 1/0/0/1/1/1",
               o_done, o_done_rej, o_done_id, o_clk_en, o_busy, o_div_ratio);
    end
    @(negedge clk);
    checks++;
    if ({o_done, o_busy, o_clk_en} !== 3'b001) begin
      errors++;
      $display("FAIL same_T+2 got done=%0d busy=%0d en=%0d exp 0/0/1", o_done, o_busy, o_clk_en);
    end
    step(1);
  endtask

  task automatic test_reset_mid;
    int n;
    i_req0_valid = 1'b1;
    i_req0_ratio = 8'd5;
    n = 0;
    @(negedge clk);
    while (!o_req0_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    // Now in the first GATE cycle; pull reset for one edge.
    i_rst = 1'b1;
    exp_q.delete();
    m_ratio = 8'd1;
    @(negedge clk);
    checks++;
    if (o_clk_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_gate got en=%0d exp 0", o_clk_en);
    end
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_clk_en, o_div_ratio, o_busy, o_done, o_req0_ready} !== {1'b1, 8'd1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_after got en=%0d ratio=%0d busy=%0d done=%0d rdy0=%0d exp 1/1/0/0/1",
               o_clk_en, o_div_ratio, o_busy, o_done, o_req0_ready);
    end
    @(posedge clk); #1;
    i_req0_valid = 1'b0;
    wait_idle();
    checks++;
    if (o_div_ratio !== 8'd5) begin
      errors++;
      $display("FAIL rstmid_final got %0d exp 5", o_div_ratio);
    end
  endtask

  task automatic test_fast;
    int n;
    logic [7:0] er;
    logic       een, ebusy, edone;
    logic [2:0] est;
    f_v0 = 1'b1;
    f_r0 = 8'd3;
    n = 0;
    @(negedge clk);
    while (!f_rdy0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (f_rdy0 !== 1'b1 || f_rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL fast_ready got rdy0=%0d rdy1=%0d exp 1/0", f_rdy0, f_rdy1);
    end
    @(posedge clk); #1;
    f_v0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      een   = !(k <= 2);
      er    = (k >= 3) ? 8'd3 : 8'd1;
      edone = (k == 4);
      ebusy = (k <= 4);
      est   = (k == 1) ? 3'd1 : (k == 2) ? 3'd2 : (k == 3) ? 3'd3 : (k == 4) ? 3'd4 : 3'd0;
      checks++;
      if ({f_en, f_busy, f_done, f_done_id, f_done_rej, f_div, f_dbg} !== {een, ebusy, edone, 2'b00, er, est}) begin
        errors++;
        $display("FAIL fast_T+%0d got en=%0d busy=%0d done=%0d id=%0d rej=%0d ratio=%0d st=%0d exp en=%0d busy=%0d done=%0d ratio=%0d st=%0d",
                 k, f_en, f_busy, f_done, f_done_id, f_done_rej, f_div, f_dbg, een, ebusy, edone, er, est);
      end
    end
    step(1);
  endtask

  task automatic test_back_to_back;
    fork
      begin
        int w;
        for (int i = 0; i < 12; i++) begin
          step($urandom_range(0, 3));
          req(1'b0, 8'($urandom_range(0, 6)), w);
        end
      end
      begin
        int w;
        for (int i = 0; i < 12; i++) begin
          step($urandom_range(0, 3));
          req(1'b1, 8'($urandom_range(0, 6)), w);
        end
      end
    join
    wait_idle();
    checks++;
    if (o_div_ratio !== m_ratio) begin
      errors++;
      $display("FAIL b2b_final_ratio got %0d exp %0d", o_div_ratio, m_ratio);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_reject();
    test_same_ratio();
    test_reset_mid();
    test_fast();
    test_back_to_back();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
